// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Passive reader for a multiplexed 4-digit common-anode seven-segment bus.
//   The scanned bus is synchronised and debounced. Each stable segment pattern
//   is decoded back to a hex nibble and stored per digit. A full 4-digit frame
//   is snapshotted once every digit has been legally captured.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   segments {g,f,e,d,c,b,a}, active-low
//   an_n[3:0]    anodes, active-low, an_n[0] = digit 0
//   dp_n         decimal point, active-low
//   digits[15:0] live decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set when digit i last captured a legal pattern
//   dp_flags     captured decimal point per digit, active-high
//   frame_value  snapshot of digits taken when frame_done fires
//   frame_done   one-cycle pulse when all four digits were captured
//   decode_err   one-cycle pulse on an illegal capture
module sevenseg_scan_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   input  logic        dp_n,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic [3:0]  dp_flags,
   output logic [15:0] frame_value,
   output logic        frame_done,
   output logic        decode_err
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   // Capture fires on the edge where the counter steps onto CNT_MAX, which
   // places the output update exactly STABLE_CYCLES+2 edges after the input.
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

   state_t           state;
   logic [11:0]      s1, s2, p;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       seen;

   logic [3:0]  s_an;
   logic [6:0]  s_seg;
   logic        s_dp;
   logic        changed;
   logic        capture;
   logic        one_cold;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic        legal;
   logic [15:0] dig_upd;
   logic [3:0]  seen_upd;

   always_comb begin
      s_an     = s2[11:8];
      s_seg    = s2[7:1];
      s_dp     = s2[0];
      changed  = (s2 != p);
      capture  = (state == SETTLE) && !changed && (cnt == CNT_CAP);
      one_cold = $onehot(~s_an);

      idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!s_an[i]) idx = 2'(i);
      end

      legal = 1'b1;
      nib   = '0;
      case (s_seg)
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: legal = 1'b0;
      endcase

      dig_upd                   = digits;
      dig_upd[{idx, 2'b00} +: 4] = nib;
      seen_upd                  = seen | (4'b0001 << idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1          <= '1;
         s2          <= '1;
         p           <= '1;
         cnt         <= '0;
         seen        <= '0;
         state       <= IDLE;
         digits      <= '0;
         digit_valid <= '0;
         dp_flags    <= '0;
         frame_value <= '0;
         frame_done  <= 1'b0;
         decode_err  <= 1'b0;
      end else begin
         s1         <= {an_n, seg_n, dp_n};
         s2         <= s1;
         p          <= s2;
         frame_done <= 1'b0;
         decode_err <= 1'b0;

         if (changed)             cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

         if (changed) begin
            state <= (s_an == 4'b1111) ? IDLE : SETTLE;
         end else if (capture) begin
            state <= HELD;
            if (!one_cold) begin
               decode_err <= 1'b1;
            end else if (!legal) begin
               decode_err       <= 1'b1;
               digit_valid[idx] <= 1'b0;
            end else begin
               digits           <= dig_upd;
               digit_valid[idx] <= 1'b1;
               dp_flags[idx]    <= ~s_dp;
               if (seen_upd == 4'b1111) begin
                  frame_value <= dig_upd;
                  frame_done  <= 1'b1;
                  seen        <= '0;
               end else begin
                  seen <= seen_upd;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder
//   Directed bench for sevenseg_scan_decoder (STABLE_CYCLES=4). Inputs are
//   driven 1 time unit after a rising edge; outputs are sampled at the same
//   point. frame_done / decode_err pulses are tallied on the falling edge.
module tb_sevenseg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        dp_n;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic [3:0]  dp_flags;
   logic [15:0] frame_value;
   logic        frame_done;
   logic        decode_err;

   int total = 0;
   int bad   = 0;
   int fd_cnt = 0;
   int de_cnt = 0;
   int fd_base;
   int de_base;

   sevenseg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .dp_n        (dp_n),
      .digits      (digits),
      .digit_valid (digit_valid),
      .dp_flags    (dp_flags),
      .frame_value (frame_value),
      .frame_done  (frame_done),
      .decode_err  (decode_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (decode_err) de_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      an_n  = a;
      seg_n = s;
      dp_n  = d;
      tick(n);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      an_n  = 4'hF;
      seg_n = 7'h7F;
      dp_n  = 1'b1;
      tick(2);
      chk("rst_digits", 32'(digits), 32'h0);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_dp", 32'(dp_flags), 32'h0);
      chk("rst_frame", 32'(frame_value), 32'h0);
      chk("rst_pulses", 32'({frame_done, decode_err}), 32'h0);
      rst_n = 1'b1;
      tick(2);

      // single digit: capture lands on the 6th edge after the change
      de_base = de_cnt;
      drive(4'b1110, 7'h40, 1'b1, 5);
      chk("single_before", 32'(digit_valid), 32'h0);
      tick(1);
      chk("single_valid", 32'(digit_valid), 32'h1);
      chk("single_digits", 32'(digits), 32'h0);
      chk("single_dp", 32'(dp_flags), 32'h0);
      tick(4);
      chk("single_noerr", 32'(de_cnt - de_base), 32'h0);

      // full frame
      fd_base = fd_cnt;
      drive(4'b1110, 7'h79, 1'b1, 8);
      drive(4'b1101, 7'h24, 1'b1, 8);
      drive(4'b1011, 7'h30, 1'b1, 8);
      chk("frame_early", 32'(fd_cnt - fd_base), 32'h0);
      drive(4'b0111, 7'h19, 1'b1, 8);
      chk("frame_pulses", 32'(fd_cnt - fd_base), 32'h1);
      chk("frame_value", 32'(frame_value), 32'h4321);
      chk("frame_valid", 32'(digit_valid), 32'hF);

      // glitch filter: 3-cycle glitch ignored, 4-cycle one captured
      drive(4'b1110, 7'h12, 1'b1, 8);
      chk("glitch_hold5", 32'(digits), 32'h4325);
      fd_base = fd_cnt;
      de_base = de_cnt;
      drive(4'b1110, 7'h00, 1'b1, 3);
      drive(4'b1110, 7'h12, 1'b1, 10);
      chk("glitch3_digits", 32'(digits), 32'h4325);
      chk("glitch3_noerr", 32'(de_cnt - de_base), 32'h0);
      chk("glitch3_noframe", 32'(fd_cnt - fd_base), 32'h0);
      drive(4'b1110, 7'h00, 1'b1, 4);
      drive(4'b1110, 7'h12, 1'b1, 2);
      chk("glitch4_capt", 32'(digits), 32'h4328);
      tick(8);
      chk("glitch4_back", 32'(digits), 32'h4325);

      // illegal segment pattern on digit 2
      de_base = de_cnt;
      drive(4'b1011, 7'h7F, 1'b1, 8);
      chk("illseg_err", 32'(de_cnt - de_base), 32'h1);
      chk("illseg_valid", 32'(digit_valid), 32'hB);
      chk("illseg_digits", 32'(digits), 32'h4325);

      // two anodes active
      drive(4'b1100, 7'h40, 1'b0, 8);
      chk("illan_err", 32'(de_cnt - de_base), 32'h2);
      chk("illan_regs", {digits, 8'h0, digit_valid, dp_flags}, {16'h4325, 8'h0, 4'hB, 4'h0});

      // blanking, then digit 3 = F with dp
      de_base = de_cnt;
      drive(4'b1111, 7'h40, 1'b0, 20);
      chk("blank_regs", {digits, 8'h0, digit_valid, dp_flags}, {16'h4325, 8'h0, 4'hB, 4'h0});
      chk("blank_noerr", 32'(de_cnt - de_base), 32'h0);
      drive(4'b0111, 7'h0E, 1'b0, 8);
      chk("dp_digits", 32'(digits), 32'hF325);
      chk("dp_flags", 32'(dp_flags), 32'h8);

      // complete the pending frame (seen = digits 0 and 3)
      fd_base = fd_cnt;
      drive(4'b1101, 7'h24, 1'b1, 8);
      drive(4'b1011, 7'h30, 1'b1, 8);
      chk("frame2_pulses", 32'(fd_cnt - fd_base), 32'h1);
      chk("frame2_value", 32'(frame_value), 32'hF325);

      // three digits of a new frame, then reset mid-frame
      drive(4'b1110, 7'h02, 1'b1, 8);
      drive(4'b1101, 7'h78, 1'b1, 8);
      drive(4'b1011, 7'h10, 1'b1, 8);
      chk("mid_digits", 32'(digits), 32'hF976);
      chk("mid_noframe", 32'(fd_cnt - fd_base), 32'h1);
      an_n  = 4'hF;
      seg_n = 7'h7F;
      dp_n  = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {digits, digit_valid, dp_flags, 6'h0, frame_done, decode_err},
          32'h0);
      chk("async_rst_fv", 32'(frame_value), 32'h0);
      tick(1);
      rst_n = 1'b1;
      fd_base = fd_cnt;
      drive(4'b1110, 7'h08, 1'b1, 5);
      chk("post_rst_latency", 32'(digit_valid), 32'h0);
      tick(3);
      drive(4'b1101, 7'h03, 1'b1, 8);
      drive(4'b1011, 7'h46, 1'b1, 8);
      drive(4'b0111, 7'h21, 1'b1, 8);
      chk("post_rst_pulses", 32'(fd_cnt - fd_base), 32'h1);
      chk("post_rst_value", 32'(frame_value), 32'hDCBA);
      chk("post_rst_valid", 32'(digit_valid), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
